// File: rtl/pio_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : pio_mem_arb
// Brief    : Round-robin arbiter sharing the pio_mem_f app read port among
//            NUM_REQ requesters, throttling app reads so a pending PIO read
//            is served. Optional stats counters: PIO_MEM_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module pio_mem_arb #(
  parameter int NUM_REQ       = 4,
  parameter int ID_NBITS      = 2,
  parameter int WIDTH         = 20,
  parameter int DEPTH_NBITS   = 10,
  parameter int MAX_APP_BURST = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DEPTH_NBITS-1:0] req_addr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           rsp_valid,
  output logic [ID_NBITS-1:0]            rsp_id,
  output logic [WIDTH-1:0]               rsp_data,
  input  logic                           pio_rd,
  output logic                           app_mem_rd,
  output logic [DEPTH_NBITS-1:0]         app_mem_raddr,
  input  logic                           app_mem_ack,
  input  logic [WIDTH-1:0]               app_mem_rdata,
  output logic [15:0]                    stat_grant_cnt,
  output logic [15:0]                    stat_yield_cnt
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_YIELD = 1'b1
  } state_t;

  localparam int c_SUM_W = ID_NBITS + 1;

  state_t                  r_state;
  logic [ID_NBITS-1:0]     r_rr_ptr;
  logic [ID_NBITS-1:0]     r_id_d1;
  logic [ID_NBITS-1:0]     r_id_d2;
  logic                    r_vld_d1;
  logic                    r_vld_d2;
  logic                    r_app_mem_rd;
  logic [DEPTH_NBITS-1:0]  r_app_mem_raddr;
  logic                    r_pio_pend;
  logic [7:0]              r_burst_cnt;

  logic [ID_NBITS-1:0]     w_cand [NUM_REQ];
  logic [ID_NBITS-1:0]     w_win;
  logic [ID_NBITS-1:0]     w_rr_next;
  logic                    w_found;
  logic                    w_xfer;
  logic                    w_yield;
  logic [NUM_REQ-1:0]      w_gnt;
  logic [DEPTH_NBITS-1:0]  w_addr;

  // Candidate k is (rr_ptr + k) mod NUM_REQ; both terms < NUM_REQ so one subtract suffices.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    logic [c_SUM_W-1:0] w_sum;
    assign w_sum     = {1'b0, r_rr_ptr} + c_SUM_W'(k);
    assign w_cand[k] = (w_sum >= c_SUM_W'(NUM_REQ)) ?
                       ID_NBITS'(w_sum - c_SUM_W'(NUM_REQ)) : w_sum[ID_NBITS-1:0];
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[w_cand[k]]) begin
        w_found = 1'b1;
        w_win   = w_cand[k];
      end
    end
  end

  assign w_xfer    = rst_n && (r_state == ST_ARB) && w_found;
  assign w_yield   = w_xfer && r_pio_pend && (r_burst_cnt == 8'(MAX_APP_BURST - 1));
  assign w_rr_next = (w_win == ID_NBITS'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_gnt  = '0;
    w_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == ID_NBITS'(k)) begin
        w_addr = req_addr[k*DEPTH_NBITS +: DEPTH_NBITS];
        w_gnt[k] = w_xfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_ARB;
      r_rr_ptr        <= '0;
      r_id_d1         <= '0;
      r_id_d2         <= '0;
      r_vld_d1        <= 1'b0;
      r_vld_d2        <= 1'b0;
      r_app_mem_rd    <= 1'b0;
      r_app_mem_raddr <= '0;
      r_pio_pend      <= 1'b0;
      r_burst_cnt     <= '0;
    end else begin
      r_app_mem_rd <= w_xfer;
      if (w_xfer) begin
        r_app_mem_raddr <= w_addr;
        r_rr_ptr        <= w_rr_next;
      end
      r_id_d1  <= w_win;
      r_vld_d1 <= w_xfer;
      r_id_d2  <= r_id_d1;
      r_vld_d2 <= r_vld_d1;

      // PIO reads only wait while an app read owns the memory port.
      r_pio_pend <= (pio_rd | r_pio_pend) & r_app_mem_rd;
      if (!r_pio_pend || !r_app_mem_rd) begin
        r_burst_cnt <= '0;
      end else if (r_burst_cnt != 8'hFF) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end

      case (r_state)
        ST_ARB:   if (w_yield) r_state <= ST_YIELD;
        ST_YIELD: r_state <= ST_ARB;
        default:  r_state <= ST_ARB;
      endcase
    end
  end

  assign gnt           = w_gnt;
  assign app_mem_rd    = r_app_mem_rd;
  assign app_mem_raddr = r_app_mem_raddr;
  assign rsp_valid     = app_mem_ack & r_vld_d2;
  assign rsp_id        = r_id_d2;
  assign rsp_data      = app_mem_rdata;

`ifdef PIO_MEM_ARB_STATS_EN
  logic [15:0] r_stat_grant_cnt;
  logic [15:0] r_stat_yield_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_grant_cnt <= '0;
      r_stat_yield_cnt <= '0;
    end else begin
      if (w_xfer && (r_stat_grant_cnt != 16'hFFFF)) r_stat_grant_cnt <= r_stat_grant_cnt + 16'd1;
      if (w_yield && (r_stat_yield_cnt != 16'hFFFF)) r_stat_yield_cnt <= r_stat_yield_cnt + 16'd1;
    end
  end

  assign stat_grant_cnt = r_stat_grant_cnt;
  assign stat_yield_cnt = r_stat_yield_cnt;
`else
  assign stat_grant_cnt = 16'h0;
  assign stat_yield_cnt = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pio_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_mem_arb
// Brief    : Self-checking bench for pio_mem_arb with a pio_mem_f read model
//            and a response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pio_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [39:0] req_addr;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [19:0] rsp_data;
  logic        pio_rd = 1'b0;
  logic        app_mem_rd;
  logic [9:0]  app_mem_raddr;
  logic        app_mem_ack = 1'b0;
  logic [19:0] app_mem_rdata = '0;
  logic [15:0] stat_grant_cnt;
  logic [15:0] stat_yield_cnt;

  logic [9:0]  addr [4];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [19:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

  pio_mem_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .pio_rd(pio_rd),
    .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr), .app_mem_ack(app_mem_ack),
    .app_mem_rdata(app_mem_rdata), .stat_grant_cnt(stat_grant_cnt),
    .stat_yield_cnt(stat_yield_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] mem_f(input logic [9:0] a);
    return {a ^ 10'h2A5, a};
  endfunction

  // pio_mem_f app port: registered read, ack one cycle after app_mem_rd.
  always @(posedge clk) begin
    app_mem_ack   <= app_mem_rd;
    app_mem_rdata <= mem_f(app_mem_raddr);
  end

  // Scoreboard: push on each transfer, pop on each response.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (rsp_valid !== 1'b0) begin
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: rsp_valid=%b id=%0d with nothing expected at cyc %0d", rsp_valid, rsp_id, cyc);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || e.id !== rsp_id || e.data !== rsp_data) begin
            n_fail++;
            $display("FAIL sb_rsp: got cyc=%0d id=%0d data=%h, expected cyc=%0d id=%0d data=%h",
                     cyc, rsp_id, rsp_data, e.cyc, e.id, e.data);
          end
        end
      end
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL sb_missing: no response at cyc %0d, expected id=%0d data=%h", e.cyc, e.id, e.data);
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i] && gnt[i]) sbq.push_back('{cyc + 2, 2'(i), mem_f(addr[i])});
      end
    end
  end

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    pio_rd = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    req = '0;
    pio_rd = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (gnt !== 4'b0 || app_mem_rd !== 1'b0 || app_mem_raddr !== 10'h0 ||
        rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b rd=%b raddr=%h vld=%b id=%0d, expected all 0",
               gnt, app_mem_rd, app_mem_raddr, rsp_valid, rsp_id);
    end
    n_chk++;
    if (stat_grant_cnt !== 16'h0 || stat_yield_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_stats: grant=%h yield=%h, expected 0 0", stat_grant_cnt, stat_yield_cnt);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    addr[2] = 10'h05A;
    req = 4'b0100;
    #1;
    n_chk++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_gnt: got %b, expected 0100", gnt);
    end
    @(negedge clk);
    req = '0;
    #1;
    n_chk++;
    if (app_mem_rd !== 1'b1 || app_mem_raddr !== 10'h05A) begin
      n_fail++;
      $display("FAIL single_mem: rd=%b raddr=%h, expected 1 05a", app_mem_rd, app_mem_raddr);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== mem_f(10'h05A)) begin
      n_fail++;
      $display("FAIL single_rsp: vld=%b id=%0d data=%h, expected 1 2 %h",
               rsp_valid, rsp_id, rsp_data, mem_f(10'h05A));
    end
    drain(3);
  endtask

  task automatic test_round_robin;
    apply_reset(2);
    for (int i = 0; i < 4; i++) addr[i] = 10'(10'h100 + i * 10'h11);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req = (k < 5) ? 4'hF : 4'h0;
      #1;
      if (k < 5) begin
        n_chk++;
        if (gnt !== 4'(1 << (k % 4))) begin
          n_fail++;
          $display("FAIL rr_gnt[%0d]: got %b, expected %b", k, gnt, 4'(1 << (k % 4)));
        end
      end
      if (k >= 2) begin
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4)) begin
          n_fail++;
          $display("FAIL rr_rsp_id[%0d]: vld=%b id=%0d, expected 1 %0d", k, rsp_valid, rsp_id, (k - 2) % 4);
        end
      end
    end
    drain(3);
  endtask

  task automatic test_pio_yield;
    int n_gr = 0;
    int gaps = 0;
    logic [15:0] y0;
    apply_reset(2);
    y0 = stat_yield_cnt;
    for (int i = 0; i < 4; i++) addr[i] = 10'(10'h200 + i * 10'h05);
    for (int k = -3; k <= 20; k++) begin
      @(negedge clk);
      req = 4'hF;
      pio_rd = (k == 0);
      #1;
      if (k == 0) begin
        n_chk++;
        if (app_mem_rd !== 1'b1) begin
          n_fail++;
          $display("FAIL yield_pre_rd: got %b, expected 1", app_mem_rd);
        end
      end
      if (k >= 1 && k <= 9 && gnt != 4'b0) n_gr++;
      if (k == 9) begin
        n_chk++;
        if (gnt !== 4'b0 || app_mem_rd !== 1'b1) begin
          n_fail++;
          $display("FAIL yield_gnt: gnt=%b rd=%b, expected 0000 1", gnt, app_mem_rd);
        end
      end
      if (k == 10) begin
        n_chk++;
        if (app_mem_rd !== 1'b0 || gnt === 4'b0) begin
          n_fail++;
          $display("FAIL yield_gap: rd=%b gnt=%b, expected rd 0 with a grant", app_mem_rd, gnt);
        end
      end
      if (k >= 11 && app_mem_rd !== 1'b1) gaps++;
    end
    n_chk++;
    if (n_gr != 8) begin
      n_fail++;
      $display("FAIL yield_burst: got %0d app reads while pending, expected 8", n_gr);
    end
    n_chk++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL yield_resume: got %0d idle cycles after resume, expected 0", gaps);
    end
`ifdef PIO_MEM_ARB_STATS_EN
    n_chk++;
    if (stat_yield_cnt !== y0 + 16'd1) begin
      n_fail++;
      $display("FAIL yield_stat: got %h, expected %h", stat_yield_cnt, y0 + 16'd1);
    end
`else
    n_chk++;
    if (stat_yield_cnt !== y0) begin
      n_fail++;
      $display("FAIL yield_stat: got %h, expected %h", stat_yield_cnt, y0);
    end
`endif
    drain(3);
  endtask

  task automatic test_pio_idle;
    int gaps = 0;
    logic [15:0] y0;
    y0 = stat_yield_cnt;
    @(negedge clk);
    req = '0;
    pio_rd = 1'b1;
    @(negedge clk);
    pio_rd = 1'b0;
    #1;
    n_chk++;
    if (app_mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_rd: got %b, expected 0", app_mem_rd);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req = 4'hF;
      #1;
      if (k >= 1 && (app_mem_rd !== 1'b1 || gnt === 4'b0)) gaps++;
    end
    n_chk++;
    if (gaps != 0) begin
      n_fail++;
      $display("FAIL idle_no_yield: got %0d stalled cycles, expected 0", gaps);
    end
    n_chk++;
    if (stat_yield_cnt !== y0) begin
      n_fail++;
      $display("FAIL idle_stat: got %h, expected %h", stat_yield_cnt, y0);
    end
    drain(3);
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    apply_reset(2);
    @(negedge clk);
    addr[2] = 10'h333;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (app_mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_rd: got %b, expected 0", app_mem_rd);
    end
    if (rsp_valid !== 1'b0) seen++;
    @(negedge clk);
    #1;
    if (rsp_valid !== 1'b0) seen++;
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_rsp: got %0d cycles of rsp_valid, expected 0", seen);
    end
    @(negedge clk);
    req = 4'hF;
    #1;
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_rr: got %b, expected 0001", gnt);
    end
    drain(4);
  endtask

  task automatic test_stats;
`ifdef PIO_MEM_ARB_STATS_EN
    apply_reset(2);
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      req = 4'hF;
    end
    drain(4);
    n_chk++;
    if (stat_grant_cnt !== 16'hFFFF || stat_yield_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL stats_sat: grant=%h yield=%h, expected ffff 0000", stat_grant_cnt, stat_yield_cnt);
    end
`else
    n_chk++;
    if (stat_grant_cnt !== 16'h0 || stat_yield_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL stats_off: grant=%h yield=%h, expected 0 0", stat_grant_cnt, stat_yield_cnt);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4; i++) addr[i] = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_pio_yield;
    test_pio_idle;
    test_reset_mid;
    test_stats;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding responses, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
